// File: rtl/pio_input_capture.sv
// Avalon-MM input PIO: synchroniser, per-bit debounce, edge select, W1C edge capture, masked IRQ.
// Define DEBOUNCE_EN to build the debounce counters and the db_thresh register (addr 6).
module pio_input_capture #(
  parameter int               WIDTH      = 10,
  parameter int               DB_CNT_W   = 16,
  parameter int               DB_RESET   = 50000,
  parameter logic [WIDTH-1:0] RISE_RESET = '1,
  parameter logic [WIDTH-1:0] FALL_RESET = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             chipselect,
  input  logic [2:0]       address,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] s1, s2, stable, prev;
  logic [WIDTH-1:0] irq_mask, edge_capture, rise_en, fall_en;
  logic [WIDTH-1:0] rise, fall, clr;
  logic             wr_en;
  logic             unused_wdata;

  assign wr_en        = chipselect && !write_n;
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= in_port;
      s2   <= s1;
      prev <= stable;
    end
  end

`ifdef DEBOUNCE_EN
  logic [DB_CNT_W-1:0] db_thresh;
  logic [DB_CNT_W-1:0] cnt     [WIDTH];
  logic [DB_CNT_W:0]   cnt_inc [WIDTH];
  logic [DB_CNT_W:0]   thresh_eff;

  // A threshold of zero is treated as one so a differing sample is accepted next edge.
  assign thresh_eff = (db_thresh == '0) ? {{DB_CNT_W{1'b0}}, 1'b1} : {1'b0, db_thresh};

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      cnt_inc[i] = {1'b0, cnt[i]} + {{DB_CNT_W{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt_inc[i] >= thresh_eff) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else if (!cnt_inc[i][DB_CNT_W]) begin
          cnt[i] <= cnt_inc[i][DB_CNT_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_thresh <= DB_CNT_W'(DB_RESET);
    end else if (wr_en && address == 3'd6) begin
      db_thresh <= writedata[DB_CNT_W-1:0];
    end
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stable <= '0;
    else          stable <= s2;
  end
`endif

  assign rise = stable & ~prev & rise_en;
  assign fall = ~stable & prev & fall_en;
  assign clr  = (wr_en && address == 3'd3) ? writedata[WIDTH-1:0] : '0;

  // New edges are OR-ed in after the clear so a simultaneous set survives the W1C.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask     <= '0;
      rise_en      <= RISE_RESET;
      fall_en      <= FALL_RESET;
      edge_capture <= '0;
    end else begin
      if (wr_en && address == 3'd2) irq_mask <= writedata[WIDTH-1:0];
      if (wr_en && address == 3'd4) rise_en  <= writedata[WIDTH-1:0];
      if (wr_en && address == 3'd5) fall_en  <= writedata[WIDTH-1:0];
      edge_capture <= (edge_capture & ~clr) | rise | fall;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      case (address)
        3'd0:    readdata <= 32'(stable);
        3'd2:    readdata <= 32'(irq_mask);
        3'd3:    readdata <= 32'(edge_capture);
        3'd4:    readdata <= 32'(rise_en);
        3'd5:    readdata <= 32'(fall_en);
`ifdef DEBOUNCE_EN
        3'd6:    readdata <= 32'(db_thresh);
`endif
        default: readdata <= '0;
      endcase
    end
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_pio_input_capture.sv
// Bench for pio_input_capture: register table, directed latency/W1C/IRQ sequences, and a
// randomized run checked every cycle against a run-length reference model.
module tb_pio_input_capture;

  localparam int W = 10;
`ifdef DEBOUNCE_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic          clk, reset_n, chipselect, write_n, irq;
  logic [2:0]    address;
  logic [31:0]   writedata, readdata;
  logic [W-1:0]  in_port;
  int            total, bad;

  pio_input_capture dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .chipselect (chipselect),
    .address    (address),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a bit's debounced level adopts the synchronised sample once that
  // sample has held the opposite value for at least the threshold number of edges.
  logic [W-1:0] m_s1, m_s2, m_stable, m_prev, m_cap, m_mask, m_rise, m_fall, m_runval;
  logic [W-1:0] m_nxt, m_up, m_down, m_clr;
  logic [15:0]  m_thresh;
  logic [31:0]  m_rd, m_rdn;
  int           m_runlen [W];
  int           m_t;
  logic         m_irq;

  assign m_irq = |(m_cap & m_mask);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_prev = '0; m_cap = '0;
      m_mask = '0; m_rise = '1; m_fall = '0; m_runval = '0;
      m_thresh = 16'd50000; m_rd = '0;
      for (int i = 0; i < W; i++) m_runlen[i] = 0;
    end else begin
      case (address)
        3'd0:    m_rdn = 32'(m_stable);
        3'd2:    m_rdn = 32'(m_mask);
        3'd3:    m_rdn = 32'(m_cap);
        3'd4:    m_rdn = 32'(m_rise);
        3'd5:    m_rdn = 32'(m_fall);
        3'd6:    m_rdn = DB ? 32'(m_thresh) : 32'd0;
        default: m_rdn = 32'd0;
      endcase
      m_t = (!DB || m_thresh == 16'd0) ? 1 : int'(m_thresh);
      for (int i = 0; i < W; i++) begin
        if (m_s2[i] == m_runval[i]) m_runlen[i] = m_runlen[i] + 1;
        else begin m_runval[i] = m_s2[i]; m_runlen[i] = 1; end
        m_nxt[i] = (m_s2[i] != m_stable[i] && m_runlen[i] >= m_t) ? m_s2[i] : m_stable[i];
      end
      m_up   = m_stable & ~m_prev & m_rise;
      m_down = ~m_stable & m_prev & m_fall;
      m_clr  = (chipselect && !write_n && address == 3'd3) ? writedata[W-1:0] : '0;
      m_cap  = (m_cap & ~m_clr) | m_up | m_down;
      if (chipselect && !write_n) begin
        case (address)
          3'd2: m_mask = writedata[W-1:0];
          3'd4: m_rise = writedata[W-1:0];
          3'd5: m_fall = writedata[W-1:0];
          3'd6: if (DB) m_thresh = writedata[15:0];
          default: ;
        endcase
      end
      m_prev = m_stable; m_stable = m_nxt;
      m_s2 = m_s1; m_s1 = in_port; m_rd = m_rdn;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      checkOutput("model_readdata", readdata, m_rd);
      checkOutput("model_irq", 32'(irq), 32'(m_irq));
    end
  end

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  task automatic busWrite(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  // One table entry: optional write, then a read of the same address one edge later.
  task automatic applyStimulus(input vec_t v, input int idx);
    if (v.wr) busWrite(v.addr, v.wdata);
    address = v.addr;
    @(negedge clk);
    checkOutput($sformatf("table[%0d] addr%0d", idx, v.addr), readdata, v.exp);
    checkOutput($sformatf("table[%0d] irq", idx), 32'(irq), 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  vec_t vecs[$];
  int   lat;
  int   hot_bit;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    total = 0; bad = 0;
    chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0; in_port = '0;
    reset_n = 1'b0;
    idle(3);
    reset_n = 1'b1;

    vecs.push_back('{1'b0, 3'd0, 32'd0, 32'd0});
    vecs.push_back('{1'b0, 3'd1, 32'd0, 32'd0});
    vecs.push_back('{1'b0, 3'd2, 32'd0, 32'd0});
    vecs.push_back('{1'b0, 3'd3, 32'd0, 32'd0});
    vecs.push_back('{1'b0, 3'd4, 32'd0, 32'h3FF});
    vecs.push_back('{1'b0, 3'd5, 32'd0, 32'd0});
    vecs.push_back('{1'b0, 3'd6, 32'd0, DB ? 32'd50000 : 32'd0});
    vecs.push_back('{1'b0, 3'd7, 32'd0, 32'd0});
    vecs.push_back('{1'b1, 3'd2, 32'hFFFF_F155, 32'h155});
    vecs.push_back('{1'b1, 3'd4, 32'h0000_00F0, 32'h0F0});
    vecs.push_back('{1'b1, 3'd5, 32'hFFFF_FFFF, 32'h3FF});
    vecs.push_back('{1'b1, 3'd3, 32'hFFFF_FFFF, 32'd0});
    vecs.push_back('{1'b1, 3'd1, 32'h0000_1234, 32'd0});
    vecs.push_back('{1'b1, 3'd7, 32'h0000_ABCD, 32'd0});
    vecs.push_back('{1'b1, 3'd0, 32'h0000_00FF, 32'd0});
    vecs.push_back('{1'b1, 3'd6, 32'd5, DB ? 32'd5 : 32'd0});
    vecs.push_back('{1'b1, 3'd4, 32'h3FF, 32'h3FF});
    vecs.push_back('{1'b1, 3'd5, 32'd0, 32'd0});
    vecs.push_back('{1'b1, 3'd2, 32'd0, 32'd0});
    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

    if (DB) begin
      busWrite(3'd6, 32'd4);
      // A 3-cycle glitch is shorter than the threshold of 4 and must vanish.
      address = 3'd0;
      in_port = 10'h001; idle(3);
      in_port = 10'h000; idle(10);
      checkOutput("glitch_data", readdata, 32'd0);
      address = 3'd3; idle(2);
      checkOutput("glitch_capture", readdata, 32'd0);
    end

    // Level latency: change -> readdata is 2 sync + threshold + 1 read register.
    lat     = DB ? 7 : 4;
    hot_bit = DB ? 0 : 3;
    address = 3'd0;
    in_port = W'(1) << hot_bit;
    idle(lat - 1);
    checkOutput("level_before_latency", readdata, 32'd0);
    idle(1);
    checkOutput("level_at_latency", readdata, 32'(1) << hot_bit);
    idle(10 - lat);
    in_port = '0;
    idle(12);
    address = 3'd3; idle(2);
    checkOutput("rise_capture", readdata, 32'(1) << hot_bit);
    busWrite(3'd3, 32'h3FF);
    idle(1);
    checkOutput("capture_cleared", readdata, 32'd0);

    // Falling-edge select on bit 1 only; bit 2 edges are disabled in both directions.
    busWrite(3'd4, 32'd0);
    busWrite(3'd5, 32'h002);
    in_port = 10'h006; idle(15);
    in_port = 10'h000; idle(15);
    in_port = 10'h004; idle(15);
    in_port = 10'h000; idle(15);
    address = 3'd3; idle(2);
    checkOutput("fall_capture", readdata, 32'h002);
    busWrite(3'd3, 32'h3FF);
    busWrite(3'd4, 32'h3FF);
    busWrite(3'd5, 32'd0);

    busWrite(3'd2, 32'h001);
    in_port = 10'h001; idle(15);
    checkOutput("irq_on_masked_capture", 32'(irq), 32'd1);
    busWrite(3'd3, 32'h002);
    checkOutput("irq_after_other_w1c", 32'(irq), 32'd1);
    busWrite(3'd3, 32'h001);
    checkOutput("irq_after_w1c", 32'(irq), 32'd0);

    // Clear lands on the very edge that sets bit 0 from a new rise: the set must survive.
    in_port = 10'h000; idle(15);
    in_port = 10'h001;
    idle(lat - 1);
    busWrite(3'd3, 32'h001);
    idle(1);
    checkOutput("w1c_vs_set_capture", readdata, 32'h001);
    checkOutput("w1c_vs_set_irq", 32'(irq), 32'd1);
    busWrite(3'd3, 32'h001);
    checkOutput("irq_final_clear", 32'(irq), 32'd0);

    if (DB) busWrite(3'd6, 32'd3);
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 7) == 0) in_port = in_port ^ (W'(1) << $urandom_range(0, W - 1));
      address    = 3'($urandom_range(0, 7));
      chipselect = ($urandom_range(0, 3) != 0);
      write_n    = ($urandom_range(0, 3) != 0);
      writedata  = (address == 3'd6) ? 32'($urandom_range(0, 6)) : $urandom;
      if (c == 1200) begin
        #2 reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        busWrite(3'd6, 32'd2);
      end
      @(negedge clk);
    end
    chipselect = 1'b0; write_n = 1'b1;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
